// File: rtl/ds1302_pkg.sv
// Shared codes, DS1302 register constants and sequencer state encoding.
package ds1302_pkg;

  localparam logic [1:0] FUNC_IDLE  = 2'b00;
  localparam logic [1:0] FUNC_WRITE = 2'b10;
  localparam logic [1:0] FUNC_READ  = 2'b01;

  localparam logic [4:0] WP_REG = 5'd7;
  localparam logic [7:0] WP_OFF = 8'h00;
  localparam logic [7:0] WP_ON  = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPROT = 3'd1,
    S_GAP    = 3'd2,
    S_XFER   = 3'd3,
    S_PROT   = 3'd4,
    S_DONE   = 3'd5
  } seq_state_t;

  // DS1302 command byte: MSB always 1, bit 6 selects RAM, bit 0 selects read.
  function automatic logic [7:0] ds_addr_byte(input logic ram, input logic [4:0] addr,
                                              input logic rd);
    return {1'b1, ram, addr, rd};
  endfunction

endpackage

// File: rtl/ds_byte_timer.sv
// Per-byte watchdog: counts while enabled, flags the last allowed cycle.
module ds_byte_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  // High during the TIMEOUT-th cycle of a byte, so a silent engine sees start for exactly TIMEOUT cycles.
  assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ds_cmd_sequencer.sv
// Turns one multi-byte DS1302 command into a series of byte starts for the function engine,
// bracketing writes with write-protect off/on and aborting on a silent engine.
module ds_cmd_sequencer
  import ds1302_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 1024,
  parameter int AUTO_WP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  // Handshake: a command is taken on a cycle where cmd_valid and cmd_ready are both high;
  // cmd_ready is only high in idle, and cmd_done pulses once per taken command.
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic                 cmd_ram,
  input  logic [4:0]           cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic [8*MAX_LEN-1:0] cmd_wdata,
  output logic                 cmd_done,
  output logic                 cmd_err,
  output logic [8*MAX_LEN-1:0] rd_data,
  output logic [1:0]           func_start,
  input  logic                 func_done,
  input  logic [7:0]           func_rdata,
  output logic [7:0]           register_addr,
  output logic [7:0]           write_data,
  output logic [2:0]           dbg_state
);

  seq_state_t           state;
  logic                 write_q;
  logic                 ram_q;
  logic [4:0]           addr_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     idx;
  logic [8*MAX_LEN-1:0] payload_q;
  logic                 wp_q;
  logic                 prot_pend;
  logic                 err_q;

  logic [LEN_W-1:0]     len_eff;
  logic [4:0]           wp_dist;
  logic                 covers_wp;
  logic                 wp_en;
  logic                 in_byte;
  logic                 expired;
  logic                 last_byte;

  always_comb begin
    len_eff = cmd_len;
    if (cmd_len == '0) begin
      len_eff = LEN_W'(1);
    end else if (32'(cmd_len) > MAX_LEN) begin
      len_eff = LEN_W'(MAX_LEN);
    end
  end

  // Writes that themselves touch the WP register must not be bracketed, or PROT would undo them.
  assign wp_dist   = WP_REG - cmd_addr;
  assign covers_wp = (32'(wp_dist) < 32'(len_eff));
  assign wp_en     = (AUTO_WP != 0) && cmd_write && !(!cmd_ram && covers_wp);

  assign in_byte   = (state == S_UNPROT) || (state == S_XFER) || (state == S_PROT);
  assign last_byte = (idx == len_q - LEN_W'(1));
  assign dbg_state = state;

  ds_byte_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_byte),
    .en      (in_byte),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cmd_ready     <= 1'b0;
      cmd_done      <= 1'b0;
      cmd_err       <= 1'b0;
      rd_data       <= '0;
      func_start    <= FUNC_IDLE;
      register_addr <= '0;
      write_data    <= '0;
      write_q       <= 1'b0;
      ram_q         <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      idx           <= '0;
      payload_q     <= '0;
      wp_q          <= 1'b0;
      prot_pend     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            write_q   <= cmd_write;
            ram_q     <= cmd_ram;
            addr_q    <= cmd_addr;
            len_q     <= len_eff;
            payload_q <= cmd_wdata;
            wp_q      <= wp_en;
            idx       <= '0;
            prot_pend <= 1'b0;
            err_q     <= 1'b0;
            if (wp_en) begin
              state         <= S_UNPROT;
              register_addr <= ds_addr_byte(1'b0, WP_REG, 1'b0);
              write_data    <= WP_OFF;
              func_start    <= FUNC_WRITE;
            end else begin
              state         <= S_XFER;
              register_addr <= ds_addr_byte(cmd_ram, cmd_addr, !cmd_write);
              write_data    <= cmd_write ? cmd_wdata[7:0] : 8'h00;
              func_start    <= cmd_write ? FUNC_WRITE : FUNC_READ;
            end
          end
        end
        S_UNPROT: begin
          if (func_done) begin
            func_start <= FUNC_IDLE;
            state      <= S_GAP;
          end else if (expired) begin
            func_start <= FUNC_IDLE;
            err_q      <= 1'b1;
            cmd_done   <= 1'b1;
            cmd_err    <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_XFER: begin
          if (func_done) begin
            func_start <= FUNC_IDLE;
            if (!write_q) begin
              rd_data[8*int'(idx) +: 8] <= func_rdata;
            end
            if (!last_byte) begin
              idx   <= idx + LEN_W'(1);
              state <= S_GAP;
            end else if (wp_q) begin
              prot_pend <= 1'b1;
              state     <= S_GAP;
            end else begin
              cmd_done <= 1'b1;
              cmd_err  <= err_q;
              state    <= S_DONE;
            end
          end else if (expired) begin
            func_start <= FUNC_IDLE;
            err_q      <= 1'b1;
            if (wp_q) begin
              prot_pend <= 1'b1;
              state     <= S_GAP;
            end else begin
              cmd_done <= 1'b1;
              cmd_err  <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_GAP: begin
          if (prot_pend) begin
            state         <= S_PROT;
            register_addr <= ds_addr_byte(1'b0, WP_REG, 1'b0);
            write_data    <= WP_ON;
            func_start    <= FUNC_WRITE;
          end else begin
            state         <= S_XFER;
            register_addr <= ds_addr_byte(ram_q, 5'(addr_q + 5'(idx)), !write_q);
            write_data    <= write_q ? payload_q[8*int'(idx) +: 8] : 8'h00;
            func_start    <= write_q ? FUNC_WRITE : FUNC_READ;
          end
        end
        S_PROT: begin
          if (func_done || expired) begin
            func_start <= FUNC_IDLE;
            err_q      <= err_q | !func_done;
            cmd_done   <= 1'b1;
            cmd_err    <= err_q | !func_done;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ds_cmd_sequencer.sv
// Randomized and directed checks of the command sequencer against a transaction-level model.
module tb_ds_cmd_sequencer;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 20;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic                 cmd_write = 1'b0;
  logic                 cmd_ram = 1'b0;
  logic [4:0]           cmd_addr = '0;
  logic [LEN_W-1:0]     cmd_len = '0;
  logic [8*MAX_LEN-1:0] cmd_wdata = '0;
  logic                 cmd_done;
  logic                 cmd_err;
  logic [8*MAX_LEN-1:0] rd_data;
  logic [1:0]           func_start;
  logic                 func_done = 1'b0;
  logic [7:0]           func_rdata = '0;
  logic [7:0]           register_addr;
  logic [7:0]           write_data;
  logic [2:0]           dbg_state;

  always #5 clk = ~clk;

  ds_cmd_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .AUTO_WP(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_ram(cmd_ram), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_wdata(cmd_wdata), .cmd_done(cmd_done), .cmd_err(cmd_err), .rd_data(rd_data),
    .func_start(func_start), .func_done(func_done), .func_rdata(func_rdata),
    .register_addr(register_addr), .write_data(write_data), .dbg_state(dbg_state)
  );

  // Transaction = {start code, register address, written byte (0 for reads)}
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  logic [17:0] m_q[$];
  logic [7:0]  ret_bytes[MAX_LEN];
  logic [63:0] model_rd = '0;
  bit          exp_err;
  int          n_vec = 0;
  int          n_err = 0;
  int          hang_idx = -1;
  int          txn_no = 0;
  int          rd_cnt = 0;
  bit          rst_test = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Function engine model: answers each new start after a random delay, or never for hang_idx.
  initial begin
    logic [1:0] code;
    int dly;
    int hi;
    forever begin
      @(negedge clk);
      if (!rst && func_start != 2'b00) begin
        code = func_start;
        obs_q.push_back({code, register_addr, (code == 2'b10) ? write_data : 8'h00});
        if (txn_no == hang_idx) begin
          hi = 0;
          while (func_start != 2'b00 && !rst && hi < TIMEOUT + 5) begin
            hi++;
            @(negedge clk);
          end
          if (!rst_test) chk("timeout_len", hi, TIMEOUT);
        end else begin
          dly = $urandom_range(1, 4);
          for (int i = 1; i < dly; i++) begin
            @(negedge clk);
            chk("start_hold", func_start, code);
          end
          func_done = 1'b1;
          if (code == 2'b01 && rd_cnt < MAX_LEN) begin
            func_rdata = ret_bytes[rd_cnt];
            rd_cnt++;
          end
          @(negedge clk);
          func_done  = 1'b0;
          func_rdata = 8'($urandom);
          chk("start_drop", func_start, 2'b00);
        end
        txn_no++;
      end
    end
  end

  // Transaction-level reference: what byte accesses one command must produce.
  task automatic model_build(input bit w, input bit ram, input logic [4:0] addr,
                             input logic [3:0] len, input logic [63:0] wd, input int h);
    int le;
    int first;
    bit cov;
    bit wp;
    logic [4:0] a;
    logic [17:0] full[$];
    le = (len == 0) ? 1 : ((int'(len) > MAX_LEN) ? MAX_LEN : int'(len));
    cov = 0;
    for (int k = 0; k < le; k++) if (((int'(addr) + k) % 32) == 7) cov = 1;
    wp = w && !(!ram && cov);
    full.delete();
    if (wp) full.push_back({2'b10, 8'h8E, 8'h00});
    for (int k = 0; k < le; k++) begin
      a = 5'((int'(addr) + k) % 32);
      full.push_back({(w ? 2'b10 : 2'b01), 1'b1, ram, a, !w, (w ? wd[8*k +: 8] : 8'h00)});
    end
    if (wp) full.push_back({2'b10, 8'h8E, 8'h80});
    m_q.delete();
    exp_err = 0;
    first = wp ? 1 : 0;
    if (h < 0 || h >= full.size()) begin
      m_q = full;
      if (!w) for (int k = 0; k < le; k++) model_rd[8*k +: 8] = ret_bytes[k];
    end else begin
      exp_err = 1;
      for (int i = 0; i <= h; i++) m_q.push_back(full[i]);
      if (!w) for (int k = 0; k < h - first; k++) model_rd[8*k +: 8] = ret_bytes[k];
      if (wp && h >= 1 && h <= le) m_q.push_back(full[full.size() - 1]);
    end
  endtask

  task automatic run_cmd(input bit w, input bit ram, input logic [4:0] addr,
                         input logic [3:0] len, input logic [63:0] wd);
    int cyc;
    bit seen;
    cyc = 0;
    while (!cmd_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_before", cmd_ready, 1);
    obs_q.delete();
    txn_no = 0;
    rd_cnt = 0;
    cmd_write = w; cmd_ram = ram; cmd_addr = addr; cmd_len = len; cmd_wdata = wd;
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("ready_busy", cmd_ready, 0);
    cmd_write = 1'($urandom); cmd_ram = 1'($urandom); cmd_addr = 5'($urandom);
    cmd_len = 4'($urandom); cmd_wdata = {$urandom, $urandom};
    seen = 0;
    for (cyc = 0; cyc < 2000 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 0) cmd_valid = 1'b0;
      if (cmd_done) seen = 1;
    end
    chk("done_seen", seen, 1);
    chk("cmd_err", cmd_err, exp_err);
    chk("ready_in_done", cmd_ready, 0);
    chk("rd_data", rd_data, model_rd);
    @(negedge clk);
    chk("done_pulse", cmd_done, 0);
    chk("ready_after", cmd_ready, 1);
    chk("txn_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) chk($sformatf("txn%0d", i), obs_q[i], exp_q[i]);
  endtask

  task automatic rand_ret();
    for (int k = 0; k < MAX_LEN; k++) ret_bytes[k] = 8'($urandom);
  endtask

  initial begin
    bit w, ram;
    logic [4:0] addr;
    logic [3:0] len;
    logic [63:0] wd;
    rand_ret();
    repeat (3) @(negedge clk);
    chk("rst_start", func_start, 0);
    chk("rst_done", cmd_done, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_addr", register_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_post_rst", cmd_ready, 1);

    // Clock reg 2 write, bracketed by WP off/on
    hang_idx = -1;
    model_build(1, 0, 5'd2, 4'd1, 64'h20, -1);
    exp_q = '{{2'b10, 8'h8E, 8'h00}, {2'b10, 8'h84, 8'h20}, {2'b10, 8'h8E, 8'h80}};
    run_cmd(1, 0, 5'd2, 4'd1, 64'h20);

    // Three-byte clock read
    ret_bytes[0] = 8'h12; ret_bytes[1] = 8'h34; ret_bytes[2] = 8'h56;
    model_build(0, 0, 5'd0, 4'd3, 64'h0, -1);
    exp_q = '{{2'b01, 8'h81, 8'h00}, {2'b01, 8'h83, 8'h00}, {2'b01, 8'h85, 8'h00}};
    run_cmd(0, 0, 5'd0, 4'd3, 64'h0);
    chk("rd_lit", rd_data[23:0], 24'h563412);

    // RAM write wrapping 31 -> 0
    model_build(1, 1, 5'd30, 4'd3, 64'hCCBBAA, -1);
    exp_q = '{{2'b10, 8'h8E, 8'h00}, {2'b10, 8'hFC, 8'hAA}, {2'b10, 8'hFE, 8'hBB},
              {2'b10, 8'hC0, 8'hCC}, {2'b10, 8'h8E, 8'h80}};
    run_cmd(1, 1, 5'd30, 4'd3, 64'hCCBBAA);

    // Direct write to the WP register: no bracketing
    model_build(1, 0, 5'd7, 4'd1, 64'h80, -1);
    exp_q = '{{2'b10, 8'h8E, 8'h80}};
    run_cmd(1, 0, 5'd7, 4'd1, 64'h80);

    // Engine silent on the first data byte of a two-byte write
    hang_idx = 1;
    model_build(1, 0, 5'd0, 4'd2, 64'h2211, 1);
    exp_q = '{{2'b10, 8'h8E, 8'h00}, {2'b10, 8'h80, 8'h11}, {2'b10, 8'h8E, 8'h80}};
    run_cmd(1, 0, 5'd0, 4'd2, 64'h2211);
    chk("err_lit", exp_err, 1);
    hang_idx = -1;

    // Reset while a read byte is outstanding
    rst_test = 1'b1;
    hang_idx = 0;
    txn_no = 0;
    obs_q.delete();
    cmd_write = 0; cmd_ram = 0; cmd_addr = 5'd0; cmd_len = 4'd3; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_start", func_start, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_start", func_start, 0);
    chk("mid_rst_done", cmd_done, 0);
    chk("mid_rst_rd", rd_data, 0);
    model_rd = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", cmd_ready, 1);
    repeat (2) begin
      @(negedge clk);
      chk("no_prot", func_start, 0);
    end
    rst_test = 1'b0;
    hang_idx = -1;

    // Randomized commands, some with a silent engine
    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom); ram = 1'($urandom); addr = 5'($urandom);
      len = 4'($urandom_range(0, 15)); wd = {$urandom, $urandom};
      rand_ret();
      hang_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : -1;
      model_build(w, ram, addr, len, wd, hang_idx);
      exp_q = m_q;
      run_cmd(w, ram, addr, len, wd);
    end
    hang_idx = -1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
